// File: rtl/ahb_pkg.sv
// AHB encodings and burst helpers shared by the arbiter and the master agents.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    function automatic logic [3:0] burst_len_m1(input hburst_e b);
        case (b)
            WRAP4,  INCR4:  return 4'd3;
            WRAP8,  INCR8:  return 4'd7;
            WRAP16, INCR16: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

    function automatic logic is_fixed_burst(input hburst_e b);
        return (b != SINGLE) && (b != INCR);
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module ahb_rr_picker #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         valid
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!valid && req[idx[W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with fixed-burst tracking and locked-transfer hold.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    htrans_e       trans;
    hburst_e       burst;
    logic [MW-1:0] owner;
    logic [MW-1:0] rr_last;
    logic [MW-1:0] pick_idx;
    logic [MW-1:0] next_owner;
    logic          pick_valid;
    logic          hold_burst;
    logic          arb_ok;
    logic [3:0]    beats_left;
    logic [3:0]    beats_next;

    assign trans = htrans_e'(htrans);
    assign burst = hburst_e'(hburst);

    ahb_rr_picker #(
        .N (NUM_MASTERS),
        .W (MW)
    ) u_picker (
        .req    (hbusreq),
        .last   (rr_last),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // The last SEQ beat (beats_left==1) is not held, so the next grant
    // overlaps that final address phase.
    always_comb begin
        hold_burst = 1'b0;
        case (trans)
            NONSEQ:  hold_burst = is_fixed_burst(burst);
            SEQ:     hold_burst = (beats_left > 4'd1);
            BUSY:    hold_burst = (beats_left != 4'd0);
            default: hold_burst = 1'b0;
        endcase
        arb_ok     = hready && !hlock[owner] && !hold_burst;
        next_owner = pick_valid ? pick_idx : DEF_IDX;
    end

    always_comb begin
        beats_next = beats_left;
        case (trans)
            NONSEQ:  beats_next = burst_len_m1(burst);
            SEQ:     beats_next = (beats_left != 4'd0) ? beats_left - 4'd1 : beats_left;
            IDLE:    beats_next = '0;
            default: beats_next = beats_left;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            owner      <= DEF_IDX;
            rr_last    <= DEF_IDX;
            beats_left <= '0;
            hmaster    <= DEF_IDX;
            hmastlock  <= 1'b0;
        end else if (hready) begin
            beats_left <= beats_next;
            hmaster    <= owner;
            hmastlock  <= hlock[owner];
            if (arb_ok) begin
                owner   <= next_owner;
                rr_last <= next_owner;
            end
        end
    end

    assign hgrant = NUM_MASTERS'(1) << owner;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_ahb_arbiter;

    localparam int N = 4;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5;

    logic         hclk = 1'b0;
    logic         hreset = 1'b1;
    logic [N-1:0] hbusreq = '0;
    logic [N-1:0] hlock = '0;
    logic [1:0]   htrans = T_IDLE;
    logic [2:0]   hburst = B_SINGLE;
    logic         hready = 1'b1;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic         hmastlock;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: granted master, last winner, beats remaining, address-phase owner/lock.
    int m_own = 0, m_rr = 0, m_bl = 0, m_mst = 0;
    logic m_lck = 1'b0;

    ahb_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    // Drive one cycle of inputs, advance the model by the arbitration rules, sample #1 after the edge.
    task automatic step(input logic rst, input logic rdy, input logic [N-1:0] req,
                        input logic [N-1:0] lck, input logic [1:0] tr, input logic [2:0] bu);
        int n_own, n_rr, n_bl, n_mst, len;
        logic n_lck, fixed, blocked, found;
        hreset = rst; hready = rdy; hbusreq = req; hlock = lck; htrans = tr; hburst = bu;
        n_own = m_own; n_rr = m_rr; n_bl = m_bl; n_mst = m_mst; n_lck = m_lck;
        if (rst) begin
            n_own = 0; n_rr = 0; n_bl = 0; n_mst = 0; n_lck = 1'b0;
        end else if (rdy) begin
            fixed = (bu >= 3'd2);
            len = fixed ? (4 << ((int'(bu) - 2) / 2)) : 1;
            blocked = lck[m_own] || (tr == T_NONSEQ && fixed) ||
                      (tr == T_SEQ && m_bl > 1) || (tr == T_BUSY && m_bl > 0);
            if (tr == T_NONSEQ) n_bl = len - 1;
            else if (tr == T_SEQ && m_bl > 0) n_bl = m_bl - 1;
            else if (tr == T_IDLE) n_bl = 0;
            n_mst = m_own;
            n_lck = lck[m_own];
            if (!blocked) begin
                found = 1'b0;
                n_own = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && req[(m_rr + k) % N]) begin
                        found = 1'b1;
                        n_own = (m_rr + k) % N;
                    end
                end
                n_rr = n_own;
            end
        end
        @(posedge hclk);
        #1;
        m_own = n_own; m_rr = n_rr; m_bl = n_bl; m_mst = n_mst; m_lck = n_lck;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        compared++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: got grant=%b master=%0d lock=%b want 0001/0/0", hgrant, hmaster, hmastlock);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, '0, '0, T_IDLE, B_SINGLE);
            compared++;
            if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_idle[%0d]: got grant=%b master=%0d lock=%b want 0001/0/0",
                         i, hgrant, hmaster, hmastlock);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] wg [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        int         wm [5] = '{0, 1, 2, 3, 0};
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'b1111, '0, T_NONSEQ, B_SINGLE);
            compared++;
            if (hgrant !== wg[i] || int'(hmaster) != wm[i]) begin
                mismatched++;
                $display("FAIL round_robin[%0d]: got grant=%b master=%0d want %b/%0d",
                         i, hgrant, hmaster, wg[i], wm[i]);
            end
        end
    endtask

    task automatic test_fixed_burst();
        logic [1:0] tr [4] = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        logic [3:0] wg [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b0010, '0, T_IDLE, B_SINGLE);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'b0110, '0, tr[i], B_INCR4);
            compared++;
            if (hgrant !== wg[i] || hmaster !== 2'd1) begin
                mismatched++;
                $display("FAIL fixed_burst[%0d]: got grant=%b master=%0d want %b/1", i, hgrant, hmaster, wg[i]);
            end
        end
        step(1'b0, 1'b1, 4'b0110, '0, T_NONSEQ, B_SINGLE);
        compared++;
        if (hmaster !== 2'd2) begin
            mismatched++;
            $display("FAIL fixed_burst_handover: got master=%0d want 2", hmaster);
        end
    endtask

    task automatic test_wait_states();
        int cycles = 0;
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b0010, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b0110, '0, T_NONSEQ, B_INCR4);
        step(1'b0, 1'b1, 4'b0110, '0, T_SEQ, B_INCR4);
        cycles = 2;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'b0110, '0, T_SEQ, B_INCR4);
            cycles++;
            compared++;
            if (hgrant !== 4'b0010 || hmaster !== 2'd1) begin
                mismatched++;
                $display("FAIL wait_stall[%0d]: got grant=%b master=%0d want 0010/1", i, hgrant, hmaster);
            end
        end
        while (hgrant !== 4'b0100 && cycles < 20) begin
            step(1'b0, 1'b1, 4'b0110, '0, T_SEQ, B_INCR4);
            cycles++;
        end
        compared++;
        if (cycles != 7) begin
            mismatched++;
            $display("FAIL wait_handover_delay: got %0d cycles want 7", cycles);
        end
    endtask

    task automatic test_locked();
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b1000, '0, T_NONSEQ, B_SINGLE);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'b1011, 4'b1000, T_NONSEQ, B_SINGLE);
            compared++;
            if (hgrant !== 4'b1000 || hmastlock !== 1'b1) begin
                mismatched++;
                $display("FAIL locked[%0d]: got grant=%b mastlock=%b want 1000/1", i, hgrant, hmastlock);
            end
        end
        step(1'b0, 1'b1, 4'b1011, '0, T_NONSEQ, B_SINGLE);
        compared++;
        if (hgrant !== 4'b0001) begin
            mismatched++;
            $display("FAIL lock_release: got grant=%b want 0001", hgrant);
        end
    endtask

    task automatic test_early_term_and_reset();
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b0100, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b0101, '0, T_NONSEQ, B_INCR8);
        step(1'b0, 1'b1, 4'b0101, '0, T_SEQ, B_INCR8);
        step(1'b0, 1'b1, 4'b0101, '0, T_SEQ, B_INCR8);
        compared++;
        if (hgrant !== 4'b0100) begin
            mismatched++;
            $display("FAIL early_term_hold: got grant=%b want 0100", hgrant);
        end
        step(1'b0, 1'b1, 4'b0101, '0, T_IDLE, B_INCR8);
        compared++;
        if (hgrant !== 4'b0001) begin
            mismatched++;
            $display("FAIL early_term_grant: got grant=%b want 0001", hgrant);
        end
        step(1'b1, 1'b1, '0, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b0100, '0, T_IDLE, B_SINGLE);
        step(1'b0, 1'b1, 4'b0101, '0, T_NONSEQ, B_INCR8);
        step(1'b0, 1'b1, 4'b0101, '0, T_SEQ, B_INCR8);
        step(1'b1, 1'b1, 4'b0101, '0, T_SEQ, B_INCR8);
        compared++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
            mismatched++;
            $display("FAIL midburst_reset: got grant=%b master=%0d lock=%b want 0001/0/0", hgrant, hmaster, hmastlock);
        end
        // A SEQ right after reset must not be held by a leftover burst count.
        step(1'b0, 1'b1, 4'b0010, '0, T_SEQ, B_INCR8);
        compared++;
        if (hgrant !== 4'b0010) begin
            mismatched++;
            $display("FAIL reset_clears_burst: got grant=%b want 0010", hgrant);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req, lck;
        for (int i = 0; i < 400; i++) begin
            req = N'($urandom);
            lck = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), req, lck,
                 2'($urandom), 3'($urandom));
            compared++;
            if (hgrant !== 4'(1 << m_own) || int'(hmaster) != m_mst || hmastlock !== m_lck) begin
                mismatched++;
                $display("FAIL random[%0d]: got grant=%b master=%0d lock=%b want %b/%0d/%b",
                         i, hgrant, hmaster, hmastlock, 4'(1 << m_own), m_mst, m_lck);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_burst();
        test_wait_states();
        test_locked();
        test_early_term_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
